// File: rtl/cpu_program_loader.sv
// Program loader: buffers host-written bytes, then streams them to the CPU
// over a ready/done_load handshake with timeout and protocol-error detection.
`timescale 1ns/1ps

module cpu_program_loader #(
    parameter int unsigned RAM_BYTES = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic       ready,
    input  logic       done_load,
    output logic       programming,
    output logic [7:0] prog_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] byte_count
);

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 5;
    localparam int unsigned TW    = 8;
    localparam logic [CW-1:0] LAST_COUNT    = CW'(RAM_BYTES);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        SEND      = 3'd2,
        WAIT_DONE = 3'd3,
        ERROR     = 3'd4
    } state_t;

    state_t        state;
    logic [TW-1:0] timeout_cnt;
    logic [7:0]    buffer [DEPTH];

    logic          write_ok;
    logic          sending;
    logic          in_transfer;
    logic          accept;
    logic          early_done;
    logic          expired;
    logic [CW-1:0] count_inc;
    logic [7:0]    first_byte;
    logic [7:0]    next_byte;

    assign write_ok    = wr_en && !busy && ({1'b0, wr_addr} < LAST_COUNT);
    assign sending     = (state == ARM) || (state == SEND);
    assign in_transfer = sending || (state == WAIT_DONE);
    // done_load outranks ready, so a simultaneous pair accepts nothing
    assign accept      = sending && ready && !done_load;
    assign early_done  = sending && done_load;
    assign expired     = in_transfer && !done_load && !accept
                         && (timeout_cnt == TIMEOUT_LIMIT);
    assign count_inc   = byte_count + CW'(1);
    // Byte 0 bypasses a host write landing on the same edge as start
    assign first_byte  = (write_ok && (wr_addr == 4'd0)) ? wr_data : buffer[0];
    assign next_byte   = buffer[count_inc[3:0]];

    // Host-writable program buffer, locked while a transfer is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                buffer[i] <= 8'h00;
            end
        end else if (write_ok) begin
            buffer[wr_addr] <= wr_data;
        end
    end

    // Transfer FSM with registered outputs and idle-cycle timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            programming <= 1'b0;
            prog_data   <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            byte_count  <= '0;
            timeout_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (early_done || expired) begin
                state       <= ERROR;
                programming <= 1'b0;
                busy        <= 1'b0;
                error       <= 1'b1;
                prog_data   <= 8'h00;
                timeout_cnt <= timeout_cnt + TW'(1);
            end else begin
                case (state)
                    IDLE, ERROR: begin
                        if (start) begin
                            state       <= ARM;
                            programming <= 1'b1;
                            busy        <= 1'b1;
                            error       <= 1'b0;
                            byte_count  <= '0;
                            timeout_cnt <= '0;
                            prog_data   <= first_byte;
                        end
                    end
                    ARM, SEND: begin
                        if (accept) begin
                            byte_count  <= count_inc;
                            timeout_cnt <= '0;
                            if (count_inc == LAST_COUNT) begin
                                state     <= WAIT_DONE;
                                prog_data <= 8'h00;
                            end else begin
                                state     <= SEND;
                                prog_data <= next_byte;
                            end
                        end else begin
                            timeout_cnt <= timeout_cnt + TW'(1);
                        end
                    end
                    WAIT_DONE: begin
                        if (done_load) begin
                            state       <= IDLE;
                            programming <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            timeout_cnt <= timeout_cnt + TW'(1);
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        programming <= 1'b0;
                        busy        <= 1'b0;
                        prog_data   <= 8'h00;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Bench for cpu_program_loader: table vectors, directed corner sequences and
// randomized traffic checked against a transaction-level reference model.
`timescale 1ns/1ps

module tb_cpu_program_loader;

    localparam int unsigned RB0 = 16;
    localparam int unsigned TO0 = 20;
    localparam int unsigned RB1 = 4;
    localparam int unsigned TO1 = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       ready;
    logic       done_load;

    logic       programming0, busy0, done0, error0;
    logic [7:0] prog_data0;
    logic [4:0] byte_count0;
    logic       programming1, busy1, done1, error1;
    logic [7:0] prog_data1;
    logic [4:0] byte_count1;

    always #5 clk = ~clk;

    cpu_program_loader #(.RAM_BYTES(RB0), .TIMEOUT(TO0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .ready(ready), .done_load(done_load),
        .programming(programming0), .prog_data(prog_data0), .busy(busy0),
        .done(done0), .error(error0), .byte_count(byte_count0)
    );

    cpu_program_loader #(.RAM_BYTES(RB1), .TIMEOUT(TO1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .ready(ready), .done_load(done_load),
        .programming(programming1), .prog_data(prog_data1), .busy(busy1),
        .done(done1), .error(error1), .byte_count(byte_count1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: m_act 0 = not transferring, 1 = bytes pending, 2 = awaiting done_load
    int         m_act  [2];
    int         m_cnt  [2];
    int         m_idle [2];
    bit         m_err  [2];
    bit         m_done [2];
    logic [7:0] m_buf  [2][16];
    int         m_rb   [2];
    int         m_to   [2];

    typedef struct {
        logic        we;
        logic [3:0]  a;
        logic [7:0]  d;
        logic        s;
        logic        r;
        logic        dl;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl [10];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k]  = 0;
            m_cnt[k]  = 0;
            m_idle[k] = 0;
            m_err[k]  = 1'b0;
            m_done[k] = 1'b0;
            for (int j = 0; j < 16; j++) m_buf[k][j] = 8'h00;
        end
    endfunction

    function automatic void model_step();
        for (int k = 0; k < 2; k++) begin
            bit was_busy;
            was_busy  = (m_act[k] != 0);
            m_done[k] = 1'b0;
            if (!was_busy && wr_en && (int'(wr_addr) < m_rb[k])) m_buf[k][wr_addr] = wr_data;
            if (m_act[k] == 0) begin
                if (start) begin
                    m_act[k]  = 1;
                    m_cnt[k]  = 0;
                    m_idle[k] = 0;
                    m_err[k]  = 1'b0;
                end
            end else if (done_load) begin
                if (m_act[k] == 2) m_done[k] = 1'b1;
                else               m_err[k]  = 1'b1;
                m_act[k] = 0;
            end else if (m_act[k] == 1 && ready) begin
                m_cnt[k]  = m_cnt[k] + 1;
                m_idle[k] = 0;
                if (m_cnt[k] == m_rb[k]) m_act[k] = 2;
            end else begin
                m_idle[k] = m_idle[k] + 1;
                if (m_idle[k] == m_to[k]) begin
                    m_act[k] = 0;
                    m_err[k] = 1'b1;
                end
            end
        end
    endfunction

    // Output vector layout: {programming, busy, done, error, byte_count, prog_data}
    function automatic logic [16:0] mk(input bit p, input bit b, input bit dn, input bit e,
                                       input int c, input logic [7:0] d);
        return {p, b, dn, e, 5'(c), d};
    endfunction

    function automatic logic [16:0] exp_vec(input int k);
        logic [7:0] d;
        d = (m_act[k] == 1) ? m_buf[k][4'(m_cnt[k])] : 8'h00;
        return mk(m_act[k] != 0, m_act[k] != 0, m_done[k], m_err[k], m_cnt[k], d);
    endfunction

    function automatic logic [16:0] act_vec(input int k);
        if (k == 0) return {programming0, busy0, done0, error0, byte_count0, prog_data0};
        return {programming1, busy1, done1, error1, byte_count1, prog_data1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] a, input logic [7:0] d,
                         input logic s, input logic r, input logic dl);
        wr_en     = we;
        wr_addr   = a;
        wr_data   = d;
        start     = s;
        ready     = r;
        done_load = dl;
    endtask

    // One clock: model advances on the edge, both DUTs compared on the falling edge
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        check("model0", 32'(act_vec(0)), 32'(exp_vec(0)));
        check("model1", 32'(act_vec(1)), 32'(exp_vec(1)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dones;
        int rp;

        m_rb[0] = int'(RB0);
        m_rb[1] = int'(RB1);
        m_to[0] = int'(TO0);
        m_to[1] = int'(TO1);
        model_reset();
        rst = 1'b1;
        drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        #12;
        check("reset0", 32'(act_vec(0)), 32'd0);
        check("reset1", 32'(act_vec(1)), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle();

        // Table: writes, start, busy lockout, early done, done_load/ready priority
        tbl[0] = '{1'b1, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 8'h00)};
        tbl[1] = '{1'b1, 4'd1, 8'h3C, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 8'h00)};
        tbl[2] = '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 8'hA5)};
        tbl[3] = '{1'b1, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 8'hA5)};
        tbl[4] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 0, 1, 8'h3C)};
        tbl[5] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 0, 2, 8'h00)};
        tbl[6] = '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, mk(1, 1, 0, 0, 2, 8'h00)};
        tbl[7] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 1, 2, 8'h00)};
        tbl[8] = '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 8'hA5)};
        tbl[9] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1, mk(0, 0, 0, 1, 0, 8'h00)};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].r, tbl[i].dl);
            cycle();
            check($sformatf("vec%0d", i), 32'(act_vec(0)), 32'(tbl[i].exp));
        end

        // Full load of 16 bytes with ready held high
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle();
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("load_byte%0d", i), 32'(prog_data0), 32'(8'h10 + i));
            drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0);
            cycle();
            if (done0) dones++;
        end
        drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("load_count", 32'(byte_count0), 32'd16);
        check("load_prog_high", 32'(programming0), 32'd1);
        drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle();
        if (done0) dones++;
        check("done_pulse", 32'(done0), 32'd1);
        check("done_prog_low", 32'(programming0), 32'd0);
        drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle();
        if (done0) dones++;
        check("done_once", 32'(dones), 32'd1);
        check("count_hold", 32'(byte_count0), 32'd16);

        // Sparse ready pulses, then early done_load after five bytes
        drive(1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle();
        for (int p = 0; p < 5; p++) begin
            for (int g = 0; g < 4; g++) begin
                drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
                cycle();
                check("sparse_hold", 32'(prog_data0), 32'(8'h10 + p));
            end
            drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0);
            cycle();
            check("sparse_count", 32'(byte_count0), 32'(p + 1));
            check("sparse_noerr", 32'(error0), 32'd0);
        end
        drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle();
        check("early_err", 32'(error0), 32'd1);
        check("early_count", 32'(byte_count0), 32'd5);
        check("early_prog", 32'(programming0), 32'd0);

        // Timeout with ready held low, then restart clears error
        drive(1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (error0 !== 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TO0));
        check("timeout_prog", 32'(programming0), 32'd0);
        drive(1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle();
        check("restart_err", 32'(error0), 32'd0);
        check("restart_prog", 32'(programming0), 32'd1);

        // Busy lockout: write and start mid-transfer are both ignored
        drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle();
        cycle();
        drive(1'b1, 4'd3, 8'hFF, 1'b1, 1'b0, 1'b0);
        cycle();
        check("lock_count", 32'(byte_count0), 32'd2);
        check("lock_busy", 32'(busy0), 32'd1);
        drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle();
        check("lock_buf3", 32'(prog_data0), 32'h13);

        // Asynchronous reset after seven bytes
        for (int i = 0; i < 4; i++) cycle();
        drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("pre_reset_count", 32'(byte_count0), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        check("async_prog", 32'(programming0), 32'd0);
        check("async_count", 32'(byte_count0), 32'd0);
        check("async_busy", 32'(busy0), 32'd0);
        check("async_data", 32'(prog_data0), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("post_reset_idle", 32'(programming0), 32'd0);
        end
        drive(1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 16; i++) begin
            check("cleared_byte", 32'(prog_data0), 32'd0);
            drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle();

        // Randomized traffic against the reference model
        rp = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rp = int'($urandom_range(5, 95));
            rst = ($urandom_range(0, 799) == 0);
            drive($urandom_range(0, 99) < 30, 4'($urandom_range(0, 15)), 8'($urandom),
                  $urandom_range(0, 99) < 8, int'($urandom_range(0, 99)) < rp,
                  $urandom_range(0, 99) < 2);
            cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_program_loader.md
CPU_PROGRAM_LOADER -- requirements
Module: cpu_program_loader

Interface
REQ-001 Parameter RAM_BYTES, default 16: number of program bytes per load; legal values 2 to 16.
REQ-002 Parameter TIMEOUT, default 255: maximum number of idle cycles allowed while waiting for ready or done_load.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 wr_en  input  1  host write strobe into the program buffer.
REQ-006 wr_addr  input  4  host buffer address.
REQ-007 wr_data  input  8  host buffer data.
REQ-008 start  input  1  single-cycle request to begin a transfer.
REQ-009 ready  input  1  CPU "ready for next byte", from CPU uio_out[1].
REQ-010 done_load  input  1  CPU "load complete", from CPU uio_out[2].
REQ-011 programming  output  1  drives CPU uio_in[0]; high for the whole transfer.
REQ-012 prog_data  output  8  drives CPU ui_in with the current program byte.
REQ-013 busy  output  1  high in every state except IDLE and ERROR.
REQ-014 done  output  1  single-cycle pulse when a transfer completes.
REQ-015 error  output  1  sticky timeout or protocol-error flag.
REQ-016 byte_count  output  5  number of bytes accepted by the CPU so far.

Function
REQ-017 The buffer SHALL hold RAM_BYTES x 8-bit registers; when wr_en is high and busy is low, wr_data is written to wr_addr at the clock edge.
REQ-018 Writes with wr_addr >= RAM_BYTES, and any write while busy is high, SHALL be ignored.
REQ-019 The FSM SHALL have five states: IDLE, ARM, SEND, WAIT_DONE and ERROR.
  - IDLE -> ARM on start.
  - ARM -> SEND on the first cycle ready is high.
  - SEND -> WAIT_DONE on acceptance of the last byte.
  - WAIT_DONE -> IDLE when done_load is high.
  - ERROR -> ARM on start.
REQ-020 programming SHALL be registered and high in ARM, SEND and WAIT_DONE, and low in IDLE and ERROR.
REQ-021 prog_data SHALL equal buffer[byte_count] in ARM and SEND, and 8'h00 in all other states.
REQ-022 Handshake: a byte is accepted on any rising edge in ARM or SEND where ready is high.
  - On acceptance, byte_count increments, so prog_data presents the next byte in the following cycle.
  - ready held high for N consecutive cycles SHALL accept N bytes.
REQ-023 When byte_count reaches RAM_BYTES, the FSM SHALL enter WAIT_DONE, and ready SHALL then be ignored.
REQ-024 On the done_load edge in WAIT_DONE:
  - the FSM returns to IDLE;
  - done pulses high for exactly one cycle;
  - byte_count holds RAM_BYTES until the next start.
REQ-025 start SHALL reset byte_count to 0 and clear error. start SHALL be ignored while busy is high.
REQ-026 A timeout counter (8 bits) SHALL clear on entry to ARM, on every accepted byte, and on entry to WAIT_DONE. It increments on every other cycle in ARM, SEND and WAIT_DONE.
REQ-027 When the timeout counter reaches TIMEOUT, the FSM SHALL enter ERROR with error=1 and programming=0.
REQ-028 done_load seen high in ARM or SEND (early completion) SHALL cause a transition to ERROR with error=1.
REQ-029 If ready and done_load are high in the same cycle in SEND, done_load SHALL take priority (ERROR), and no byte is accepted.
REQ-030 done SHALL never assert in the same cycle as error rising.

Reset
REQ-031 While rst is high, the block SHALL immediately hold the following values:
  - state = IDLE;
  - programming = 0, prog_data = 0;
  - busy = 0, done = 0, error = 0;
  - byte_count = 0;
  - timeout counter = 0;
  - all buffer bytes = 8'h00.
REQ-032 Reset asserted mid-transfer SHALL drop programming to 0 asynchronously, without waiting for a clock edge. After release, the block SHALL stay in IDLE until start.

Verification
REQ-033 Full load: write buffer[i]=8'h10+i for i=0..15, pulse start, then hold ready high for 16 cycles and pulse done_load.
  -> prog_data sequence is 8'h10..8'h1F.
  -> byte_count ends at 16.
  -> done pulses once.
  -> programming falls in the cycle after done_load.
REQ-034 Sparse ready: toggle ready high for 1 cycle every 5 cycles.
  -> exactly one byte is accepted per pulse.
  -> prog_data holds steady between pulses.
  -> no error.
REQ-035 Timeout: pulse start and keep ready low.
  -> error=1 and programming=0 exactly TIMEOUT cycles after entering ARM.
  -> a following start clears error and re-enters ARM.
REQ-036 Early done_load: assert done_load after 5 accepted bytes.
  -> ERROR state, error=1, byte_count=5.
REQ-037 Busy lockout: while busy, issue a write of 8'hFF to address 3 and a start pulse.
  -> buffer[3] is unchanged.
  -> the transfer is not restarted.
REQ-038 Reset mid-SEND: assert rst after 7 bytes.
  -> programming=0 and byte_count=0 without waiting for a clock edge.
  -> all buffer bytes read back as 8'h00.
